// File: rtl/kpg_pkg.sv
// Shared kill/propagate/generate carry encoding and prefix operator.
package kpg_pkg;

  localparam int DEFAULT_WIDTH = 32;

  // Per-position carry status; the encoding is {a&b, a|b} of the operand bits.
  typedef enum logic [1:0] {
    KILL = 2'b00,
    PROP = 2'b01,
    GEN  = 2'b11
  } kpg_t;

  // Prefix combine, x is the more significant span: a resolved x wins, a propagating x defers to y.
  function automatic kpg_t kpg_op(input kpg_t x, input kpg_t y);
    return (x == PROP) ? y : x;
  endfunction

endpackage

// File: rtl/kpg_group_prefix.sv
// N-position inclusive prefix scan over a KPG vector, with a seed entering below position 0.
// pre[i] is the combined status of positions 0..i (and the seed).
module kpg_group_prefix
  import kpg_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [2*N-1:0] kpg,
  input  logic [1:0]     seed,
  output logic [2*N-1:0] pre
);

  kpg_t acc;

  // Running prefix from the least significant position upward.
  always_comb begin
    acc = kpg_t'(seed);
    pre = '0;
    for (int unsigned i = 0; i < N; i++) begin
      acc = kpg_op(kpg_t'(kpg[2*i +: 2]), acc);
      pre[2*i +: 2] = acc;
    end
  end

endmodule

// File: rtl/kpg_sub_pipe.sv
// Three-stage pipelined subtractor diff = a - b - bin built as a + ~b + ~bin
// on a two-level KPG prefix carry network, with valid/ready on both sides.
module kpg_sub_pipe
  import kpg_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int GROUP = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int NG = WIDTH / GROUP;

  logic advance;
  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance & ~rst;

  // ---------------- Stage 1 ----------------
  logic [WIDTH-1:0]   nb_in;
  logic [2*WIDTH-1:0] kpg_in;
  assign nb_in = ~b;

  // Per-bit status: {a&nb, a|nb} lands directly on the KILL/PROP/GEN encoding.
  always_comb begin
    kpg_in = '0;
    for (int unsigned i = 0; i < WIDTH; i++)
      kpg_in[2*i +: 2] = {a[i] & nb_in[i], a[i] | nb_in[i]};
  end

  logic               v1, cin1;
  logic [WIDTH-1:0]   a1, nb1;
  logic [2*WIDTH-1:0] kpg1;

  // S1 register: operands, carry-in and per-bit status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1   <= 1'b0;
      cin1 <= 1'b0;
      a1   <= '0;
      nb1  <= '0;
      kpg1 <= '0;
    end else if (advance) begin
      v1   <= in_valid & in_ready;
      cin1 <= ~bin;
      a1   <= a;
      nb1  <= nb_in;
      kpg1 <= kpg_in;
    end
  end

  // ---------------- Stage 2 ----------------
  logic [1:0]         seed1;
  logic [2*WIDTH-1:0] pre_c;
  assign seed1 = cin1 ? 2'(GEN) : 2'(KILL);

  // Only group 0 sees the carry-in; other groups start from the identity (PROP).
  for (genvar g = 0; g < NG; g++) begin : g_grp
    logic [1:0] grp_seed;
    assign grp_seed = (g == 0) ? seed1 : 2'(PROP);
    kpg_group_prefix #(.N(GROUP)) u_pre (
      .kpg  (kpg1[2*GROUP*g +: 2*GROUP]),
      .seed (grp_seed),
      .pre  (pre_c[2*GROUP*g +: 2*GROUP])
    );
  end

  logic               v2, cin2, amsb2, bmsb2;
  logic [WIDTH-1:0]   x2;
  logic [2*WIDTH-1:0] pre2;

  // S2 register: in-group prefixes (top entry of each group is its aggregate) and half-sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2    <= 1'b0;
      cin2  <= 1'b0;
      amsb2 <= 1'b0;
      bmsb2 <= 1'b0;
      x2    <= '0;
      pre2  <= '0;
    end else if (advance) begin
      v2    <= v1;
      cin2  <= cin1;
      amsb2 <= a1[WIDTH-1];
      bmsb2 <= ~nb1[WIDTH-1];
      x2    <= a1 ^ nb1;
      pre2  <= pre_c;
    end
  end

  // ---------------- Stage 3 ----------------
  logic [2*NG-1:0] agg2, gpre;

  // Gather each group's aggregate from the top position of its in-group prefix.
  always_comb begin
    agg2 = '0;
    for (int unsigned g = 0; g < NG; g++)
      agg2[2*g +: 2] = pre2[2*(g*GROUP + GROUP - 1) +: 2];
  end

  kpg_group_prefix #(.N(NG)) u_inter (
    .kpg  (agg2),
    .seed (2'(PROP)),
    .pre  (gpre)
  );

  logic [WIDTH-1:0] carry, sum;
  logic [1:0]       bp, gc;
  logic             cout;

  // Carry into bit i is the resolved status of bit i-1: its in-group prefix, or the group carry-in when that prefix propagates.
  always_comb begin
    bp       = '0;
    gc       = '0;
    carry    = '0;
    carry[0] = cin2;
    for (int unsigned i = 1; i < WIDTH; i++) begin
      bp = pre2[2*(i-1) +: 2];
      gc = ((i-1) / GROUP == 0) ? 2'(KILL) : gpre[2*((i-1)/GROUP - 1) +: 2];
      carry[i] = (bp == 2'(GEN)) || ((bp == 2'(PROP)) && (gc == 2'(GEN)));
    end
    sum  = x2 ^ carry;
    cout = (gpre[2*NG-1 -: 2] == 2'(GEN));
  end

  // S3 register: result and flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else if (advance) begin
      out_valid <= v2;
      diff      <= sum;
      bout      <= ~cout;
      ovf       <= (amsb2 != bmsb2) && (sum[WIDTH-1] != amsb2);
      zero      <= ~|sum;
    end
  end

endmodule

// File: tb/tb_kpg_sub_pipe.sv
// Bench for kpg_sub_pipe: directed table, stall/reset sequences and a randomized
// stream scored against an arithmetic reference model.
module tb_kpg_sub_pipe;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, bin, out_valid, out_ready, bout, ovf, zero;
  logic [W-1:0] a, b, diff;

  always #5 clk = ~clk;

  kpg_sub_pipe #(.WIDTH(W), .GROUP(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .ovf(ovf), .zero(zero)
  );

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic [W-1:0] a, b;
    logic         bin;
    logic [W-1:0] d;
    logic         bo, ov, z;
  } vec_t;

  typedef struct {
    logic [W-1:0] d;
    logic         bo, ov, z;
  } res_t;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Reference: widened unsigned subtraction for borrow, signed 64-bit subtraction for overflow.
  function automatic res_t model(input logic [W-1:0] ra, input logic [W-1:0] rb, input logic rbin);
    res_t        r;
    logic [W:0]  u;
    longint      sd;
    u    = {1'b0, ra} - {1'b0, rb} - {{W{1'b0}}, rbin};
    r.d  = u[W-1:0];
    r.bo = u[W];
    sd   = longint'($signed(ra)) - longint'($signed(rb)) - longint'(rbin);
    r.ov = (sd != longint'($signed(r.d)));
    r.z  = (r.d == '0);
    return r;
  endfunction

  // Present one op on an idle pipe and wait (bounded) for its result; lat counts edges incl. the accepting one.
  task automatic run_op(input logic [W-1:0] ra, input logic [W-1:0] rb, input logic rbin, output int lat);
    @(negedge clk);
    a = ra; b = rb; bin = rbin; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("idle_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  vec_t tbl[9];
  res_t q[$];
  res_t e;
  int   lat;
  logic stalled;
  logic [W+2:0] held;
  logic seen;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{32'd36,        32'd36,        1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{32'd18,        32'd352,       1'b0, 32'hFFFFFEB2, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{32'h7FFFFFFF,  32'hFFFFFFFF,  1'b0, 32'h80000000, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{32'h80000000,  32'h00000001,  1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{32'h00000000,  32'h00000000,  1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{32'h12345678,  32'h12345678,  1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{32'hFFFFFFFF,  32'h00000000,  1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{32'h00000000,  32'hFFFFFFFF,  1'b0, 32'h00000001, 1'b1, 1'b0, 1'b0};
    tbl[8] = '{32'd5,         32'd4,         1'b1, 32'h00000000, 1'b0, 1'b0, 1'b1};

    // Reset state
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0; rst = 1'b0;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset_outputs", {out_valid, diff, bout, ovf, zero}, '0);
    chk("reset_in_ready", {63'd0, in_ready}, 64'd0);
    rst = 1'b0;

    // Directed table, one op at a time
    for (int i = 0; i < 9; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].bin, lat);
      chk($sformatf("tbl%0d_latency", i), 64'(lat), 64'd3);
      chk($sformatf("tbl%0d_result", i), {out_valid, diff, bout, ovf, zero},
          {1'b1, tbl[i].d, tbl[i].bo, tbl[i].ov, tbl[i].z});
    end

    // Back-to-back ops with a two-cycle stall when the first result appears
    @(negedge clk);
    out_ready = 1'b1; a = 32'd100; b = 32'd1; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    a = 32'd5; b = 32'd7;
    @(posedge clk); @(negedge clk);
    a = 32'd9; b = 32'd9;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      #1;
      chk($sformatf("stall%0d_hold", s), {out_valid, diff, bout, ovf, zero}, {1'b1, 32'd99, 3'b000});
      chk($sformatf("stall%0d_in_ready", s), {63'd0, in_ready}, 64'd0);
      if (s < 2) begin
        @(posedge clk); @(negedge clk);
      end
    end
    out_ready = 1'b1;
    #1;
    chk("stall_release_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); @(negedge clk);
    chk("b2b_second", {out_valid, diff, bout, ovf, zero}, {1'b1, 32'hFFFFFFFE, 3'b100});
    @(posedge clk); @(negedge clk);
    chk("b2b_third", {out_valid, diff, bout, ovf, zero}, {1'b1, 32'd0, 3'b001});
    @(posedge clk); @(negedge clk);
    chk("b2b_drained", {63'd0, out_valid}, 64'd0);

    // Asynchronous reset clears a held result immediately
    a = 32'd50; b = 32'd8; bin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); @(negedge clk);
      lat++;
    end
    chk("held_before_reset", {out_valid, diff}, {1'b1, 32'd42});
    rst = 1'b1;
    #1;
    chk("async_reset_outputs", {out_valid, diff, bout, ovf, zero}, '0);
    chk("async_reset_in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;

    // Reset with two ops in flight, then a new op on the first edge after release
    out_ready = 1'b1; a = 32'd20; b = 32'd5; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    a = 32'd30; b = 32'd1;
    @(posedge clk); @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    #1;
    chk("midflight_reset_outputs", {out_valid, diff, bout, ovf, zero}, '0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0; a = 32'd10; b = 32'd3; bin = 1'b0; in_valid = 1'b1;
    #1;
    chk("post_reset_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); @(negedge clk);
      lat++;
    end
    chk("post_reset_latency", 64'(lat), 64'd3);
    chk("post_reset_result", {out_valid, diff, bout, ovf, zero}, {1'b1, 32'd7, 3'b000});

    // Randomized stream with random backpressure, scored against the model
    stalled = 1'b0;
    held    = '0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = $urandom;
      b         = ($urandom_range(0, 7) == 0) ? a : $urandom;
      bin       = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (stalled)
        chk("rand_stall_hold", {60'd0, out_valid, held}, {60'd0, 1'b1, diff, bout, ovf, zero});
      chk("rand_in_ready", {63'd0, in_ready}, {63'd0, ~out_valid | out_ready});
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("rand_spurious_valid", {63'd0, out_valid}, 64'd0);
        end else begin
          e = q.pop_front();
          chk("rand_result", {diff, bout, ovf, zero}, {e.d, e.bo, e.ov, e.z});
        end
      end
      if (in_valid && in_ready)
        q.push_back(model(a, b, bin));
      stalled = out_valid & ~out_ready;
      held    = {diff, bout, ovf, zero};
    end

    // Drain what is still in flight
    for (int cyc = 0; cyc < 20 && q.size() != 0; cyc++) begin
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      #1;
      if (out_valid) begin
        e = q.pop_front();
        chk("drain_result", {diff, bout, ovf, zero}, {e.d, e.bo, e.ov, e.z});
      end
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
    @(posedge clk); @(negedge clk);
    seen = out_valid;
    chk("drain_no_extra", {63'd0, seen}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
